// File: rtl/online_operand_streamer.sv
// Transmit side of the online-adder test interface: latches two signed-digit
// operands and streams them MSD-first into the adder, then flushes DELAY zeros.
module online_operand_streamer #(
  parameter int N     = 6,
  parameter int C     = 3,
  parameter int DELAY = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic [N*C-1:0] x,
  input  logic [N*C-1:0] y,
  output logic           adder_reset,
  output logic           adder_en,
  output logic [C-1:0]   xi,
  output logic [C-1:0]   yi,
  output logic           z_valid,
  output logic [3:0]     z_idx,
  output logic           busy,
  output logic           done
);

  typedef enum logic [2:0] {IDLE, RST, FEED, FLUSH, DONE} state_t;

  localparam int KW = $clog2(N + DELAY + 1);
  localparam logic [KW-1:0] K_FEED_LAST = KW'(N - 1);
  localparam logic [KW-1:0] K_LAST      = KW'(N + DELAY - 1);

  state_t         state, state_nxt;
  logic [KW-1:0]  k, k_nxt;
  logic [N*C-1:0] x_sr, y_sr, x_sr_nxt, y_sr_nxt;
  logic           stream;

  logic           adder_reset_nxt, adder_en_nxt, z_valid_nxt, busy_nxt, done_nxt;
  logic [C-1:0]   xi_nxt, yi_nxt;
  logic [3:0]     z_idx_nxt;

  // Outputs are computed for the state being entered, so k always names the
  // stream cycle currently presented on xi/yi.
  always_comb begin
    state_nxt       = state;
    k_nxt           = k;
    x_sr_nxt        = x_sr;
    y_sr_nxt        = y_sr;
    stream          = 1'b0;
    adder_reset_nxt = 1'b0;
    adder_en_nxt    = 1'b0;
    xi_nxt          = '0;
    yi_nxt          = '0;
    z_valid_nxt     = 1'b0;
    z_idx_nxt       = '0;
    busy_nxt        = 1'b0;
    done_nxt        = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start && !abort) begin
          state_nxt       = RST;
          x_sr_nxt        = x;
          y_sr_nxt        = y;
          adder_reset_nxt = 1'b1;
          busy_nxt        = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      RST: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = FEED;
          k_nxt     = '0;
          stream    = 1'b1;
          xi_nxt    = x_sr[N*C-1 -: C];
          yi_nxt    = y_sr[N*C-1 -: C];
          x_sr_nxt  = x_sr << C;
          y_sr_nxt  = y_sr << C;
        end
      end
      FEED: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          k_nxt  = k + KW'(1);
          stream = 1'b1;
          if (k == K_FEED_LAST) begin
            state_nxt = FLUSH;
          end else begin
            xi_nxt   = x_sr[N*C-1 -: C];
            yi_nxt   = y_sr[N*C-1 -: C];
            x_sr_nxt = x_sr << C;
            y_sr_nxt = y_sr << C;
          end
        end
      end
      FLUSH: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (k == K_LAST) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else begin
          k_nxt  = k + KW'(1);
          stream = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // The adder emits its first result digit DELAY-1 cycles into the stream.
    if (stream) begin
      adder_en_nxt = 1'b1;
      busy_nxt     = 1'b1;
      if (int'(k_nxt) >= DELAY - 1) begin
        z_valid_nxt = 1'b1;
        z_idx_nxt   = 4'(N - (int'(k_nxt) - DELAY + 1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      k           <= '0;
      x_sr        <= '0;
      y_sr        <= '0;
      adder_reset <= 1'b0;
      adder_en    <= 1'b0;
      xi          <= '0;
      yi          <= '0;
      z_valid     <= 1'b0;
      z_idx       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      k           <= k_nxt;
      x_sr        <= x_sr_nxt;
      y_sr        <= y_sr_nxt;
      adder_reset <= adder_reset_nxt;
      adder_en    <= adder_en_nxt;
      xi          <= xi_nxt;
      yi          <= yi_nxt;
      z_valid     <= z_valid_nxt;
      z_idx       <= z_idx_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
    end
  end

endmodule
